// File: rtl/core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states and
// instruction field positions.
package core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LI   = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int INSTR_W   = 16;
  localparam int OP_LSB    = 12;
  localparam int RD_LSB    = 8;
  localparam int RS_LSB    = 4;
  localparam int RT_LSB    = 0;
  localparam int IMM8_LSB  = 0;
  localparam int IMM12_LSB = 0;

  function automatic logic [3:0] field4(input logic [INSTR_W-1:0] ins, input int lsb);
    return ins[lsb +: 4];
  endfunction

endpackage

// File: rtl/multicycle_core_if.sv
// Instruction and data memory request buses of the multicycle core.
// The core is the master; the memories sit on the slave side.
interface multicycle_core_if #(
  parameter int DW  = 4,
  parameter int AW  = 4,
  parameter int PCW = 8
);
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_valid;
  logic [15:0]    imem_rdata;
  logic           dmem_req;
  logic           dmem_we;
  logic [AW-1:0]  dmem_addr;
  logic [DW-1:0]  dmem_wdata;
  logic           dmem_ready;
  logic [DW-1:0]  dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_valid, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_valid, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/core_regfile.sv
// 16-entry register file: three combinational read ports, one synchronous
// write port, r0 hardwired to zero.
module core_regfile #(
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [3:0]    waddr,
  input  logic [DW-1:0] wdata,
  input  logic [3:0]    raddr_a,
  input  logic [3:0]    raddr_b,
  input  logic [3:0]    raddr_c,
  output logic [DW-1:0] rdata_a,
  output logic [DW-1:0] rdata_b,
  output logic [DW-1:0] rdata_c
);
  logic [DW-1:0] regs_q [16];

  // Register storage; writes to r0 are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != 4'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 4'd0) ? '0 : regs_q[raddr_a];
  assign rdata_b = (raddr_b == 4'd0) ? '0 : regs_q[raddr_b];
  assign rdata_c = (raddr_c == 4'd0) ? '0 : regs_q[raddr_c];
endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB sequencer
// with handshaked instruction and data memories and an inline ALU.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DW  = 4,
  parameter int AW  = 4,
  parameter int PCW = 8
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_core_if.master bus,
  output logic [DW-1:0]     result_out,
  output logic              zero_flag,
  output logic              halted
);
  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [15:0]    instr_q, instr_d;
  logic [DW-1:0]  opa_q, opa_d, opb_q, opb_d, opd_q, opd_d;
  logic [DW-1:0]  res_q, res_d, result_q, result_d;
  logic           zero_q, zero_d, halted_q, halted_d;
  logic           imem_req_q, imem_req_d;
  logic           dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
  logic [AW-1:0]  dmem_addr_q, dmem_addr_d;
  logic [DW-1:0]  dmem_wdata_q, dmem_wdata_d;

  logic [3:0]     op_s, rd_s, rs_s, rt_s;
  logic [7:0]     imm8_s;
  logic [11:0]    imm12_s;
  logic [DW-1:0]  rs_data_s, rt_data_s, rd_data_s, alu_s, li_s;
  logic [AW-1:0]  ea_s;
  logic [PCW-1:0] pc_inc_s, br_tgt_s, jmp_tgt_s;
  logic           is_alu_s, rf_we_s;

  assign op_s      = field4(instr_q, OP_LSB);
  assign rd_s      = field4(instr_q, RD_LSB);
  assign rs_s      = field4(instr_q, RS_LSB);
  assign rt_s      = field4(instr_q, RT_LSB);
  assign imm8_s    = instr_q[IMM8_LSB +: 8];
  assign imm12_s   = instr_q[IMM12_LSB +: 12];
  // Size casts give zero-extension or truncation as DW/AW/PCW demand
  assign li_s      = DW'(imm8_s);
  assign ea_s      = AW'(33'(opa_q) + 33'(rt_s));
  assign pc_inc_s  = pc_q + PCW'(1'b1);
  assign br_tgt_s  = pc_inc_s + PCW'($signed(rt_s));
  assign jmp_tgt_s = PCW'(imm12_s);
  assign is_alu_s  = (op_s >= OP_ADD) && (op_s <= OP_XOR);
  assign rf_we_s   = (state_q == S_WB);

  core_regfile #(.DW(DW)) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we_s),
    .waddr   (rd_s),
    .wdata   (res_q),
    .raddr_a (rs_s),
    .raddr_b (rt_s),
    .raddr_c (rd_s),
    .rdata_a (rs_data_s),
    .rdata_b (rt_data_s),
    .rdata_c (rd_data_s)
  );

  // Register-register ALU operating on operands latched in DECODE
  always_comb begin
    alu_s = '0;
    case (op_s)
      OP_ADD:  alu_s = opa_q + opb_q;
      OP_SUB:  alu_s = opa_q - opb_q;
      OP_AND:  alu_s = opa_q & opb_q;
      OP_OR:   alu_s = opa_q | opb_q;
      OP_XOR:  alu_s = opa_q ^ opb_q;
      default: alu_s = '0;
    endcase
  end

  // Sequencer next-state; requests stay up until their handshake completes
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    opd_d        = opd_q;
    res_d        = res_q;
    result_d     = result_q;
    zero_d       = zero_q;
    halted_d     = halted_q;
    imem_req_d   = imem_req_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      S_FETCH: begin
        if (imem_req_q && bus.imem_valid) begin
          instr_d    = bus.imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        opa_d   = rs_data_s;
        opb_d   = rt_data_s;
        opd_d   = rd_data_s;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_alu_s) begin
          res_d   = alu_s;
          zero_d  = (alu_s == '0);
          state_d = S_WB;
        end else begin
          case (op_s)
            OP_LI: begin
              res_d   = li_s;
              state_d = S_WB;
            end
            OP_LW, OP_SW: begin
              dmem_req_d   = 1'b1;
              dmem_we_d    = (op_s == OP_SW);
              dmem_addr_d  = ea_s;
              dmem_wdata_d = opd_q;
              state_d      = S_MEM;
            end
            OP_BEQ: begin
              pc_d       = (opd_q == opa_q) ? br_tgt_s : pc_inc_s;
              imem_req_d = 1'b1;
              state_d    = S_FETCH;
            end
            OP_JMP: begin
              pc_d       = jmp_tgt_s;
              imem_req_d = 1'b1;
              state_d    = S_FETCH;
            end
            OP_HALT: begin
              halted_d = 1'b1;
              state_d  = S_HALT;
            end
            default: begin
              pc_d       = pc_inc_s;
              imem_req_d = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
      end
      S_MEM: begin
        if (dmem_req_q && bus.dmem_ready) begin
          dmem_req_d = 1'b0;
          if (dmem_we_q) begin
            pc_d       = pc_inc_s;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end else begin
            res_d   = bus.dmem_rdata;
            state_d = S_WB;
          end
        end else begin
          dmem_req_d = 1'b1;
        end
      end
      S_WB: begin
        result_d   = res_q;
        pc_d       = pc_inc_s;
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted_d = 1'b1;
        state_d  = S_HALT;
      end
      default: begin
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        state_d    = S_FETCH;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      instr_q      <= 16'h0000;
      opa_q        <= '0;
      opb_q        <= '0;
      opd_q        <= '0;
      res_q        <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      halted_q     <= 1'b0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      opd_q        <= opd_d;
      res_q        <= res_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      halted_q     <= halted_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign result_out     = result_q;
  assign zero_flag      = zero_q;
  assign halted         = halted_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Randomized bench for multicycle_core: memory responders with wait states and
// an instruction-level reference model of the ISA.
module tb_multicycle_core;
  localparam int DW = 4, AW = 4, PCW = 8;
  localparam int DMOD = 1 << DW, AMOD = 1 << AW, PMOD = 1 << PCW;

  logic clk = 1'b0, reset = 1'b1, rst16 = 1'b1;
  logic [DW-1:0] result_out;
  logic zero_flag, halted;
  logic [15:0] result16;
  logic zero16, halted16;

  multicycle_core_if #(.DW(DW), .AW(AW), .PCW(PCW)) bus ();
  multicycle_core_if #(.DW(16), .AW(4), .PCW(8)) bus16 ();

  multicycle_core #(.DW(DW), .AW(AW), .PCW(PCW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .result_out(result_out), .zero_flag(zero_flag), .halted(halted)
  );

  multicycle_core #(.DW(16), .AW(4), .PCW(8)) dut16 (
    .clk(clk), .reset(rst16), .bus(bus16),
    .result_out(result16), .zero_flag(zero16), .halted(halted16)
  );

  always #5 clk = ~clk;

  // zero-wait memories for the wide-data instance
  logic [15:0] prog16 [256];
  assign bus16.imem_valid = bus16.imem_req;
  assign bus16.imem_rdata = prog16[bus16.imem_addr];
  assign bus16.dmem_ready = bus16.dmem_req;
  assign bus16.dmem_rdata = 16'h0000;

  logic [15:0]   imem [256];
  logic [DW-1:0] dmem [AMOD];
  int m_regs [16];
  int m_dmem [AMOD];
  int m_pc, m_result, m_zero, m_halted, m_lat, m_dwait, m_dwe, m_daddr, m_dwdata;
  int iw_lo = 0, iw_hi = 0, dw_lo = 0, dw_hi = 0;
  int n_checks = 0, n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 16'hF000;
  endtask

  task automatic gen_random(input int n);
    logic [3:0] op;
    clear_imem();
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(14, 0));
      imem[i] = {op, 4'($urandom), 4'($urandom), 4'($urandom)};
      if (op == 4'h9) imem[i][3:0] = 4'($urandom_range(7, 0));
      if (op == 4'hA) imem[i][11:0] = 12'(i + 1 + int'($urandom_range(4, 0)));
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_pc = 0; m_result = 0; m_zero = 0; m_halted = 0;
    for (int i = 0; i < AMOD; i++) begin
      dmem[i] = DW'($urandom);
      m_dmem[i] = int'(dmem[i]);
    end
  endtask

  // Architectural effect of one instruction, plus its zero-wait latency
  task automatic m_step(input logic [15:0] ins);
    int op, rd, rs, rt, a, d, v, ea, off, npc;
    op = int'(ins[15:12]); rd = int'(ins[11:8]); rs = int'(ins[7:4]); rt = int'(ins[3:0]);
    a = m_regs[rs]; d = m_regs[rd];
    v = -1; m_lat = 3; m_dwait = 0;
    npc = (m_pc + 1) % PMOD;
    case (op)
      1: v = (a + m_regs[rt]) % DMOD;
      2: v = (a - m_regs[rt] + DMOD) % DMOD;
      3: v = a & m_regs[rt];
      4: v = a | m_regs[rt];
      5: v = a ^ m_regs[rt];
      6: v = int'(ins[7:0]) % DMOD;
      7: begin
        ea = (a + rt) % AMOD; m_dwe = 0; m_daddr = ea; v = m_dmem[ea];
        m_dwait = int'($urandom_range(dw_hi, dw_lo));
      end
      8: begin
        ea = (a + rt) % AMOD; m_dwe = 1; m_daddr = ea; m_dwdata = d; m_dmem[ea] = d;
        m_lat = 4; m_dwait = int'($urandom_range(dw_hi, dw_lo));
      end
      9: if (d == a) begin
        off = (rt >= 8) ? rt - 16 : rt;
        npc = (m_pc + 1 + off + PMOD) % PMOD;
      end
      10: npc = int'(ins[11:0]) % PMOD;
      15: m_halted = 1;
      default: ;
    endcase
    if (op >= 1 && op <= 5) m_zero = (v == 0) ? 1 : 0;
    if (v >= 0) begin
      if (rd != 0) m_regs[rd] = v;
      m_result = v;
      m_lat = (op == 7) ? 5 : 4;
    end
    if (op != 15) m_pc = npc;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    bus.imem_valid = 1'b0; bus.dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_val("rst_imem_req", bus.imem_req, 0);
    check_val("rst_dmem_req", bus.dmem_req, 0);
    check_val("rst_imem_addr", bus.imem_addr, 0);
    check_val("rst_result", result_out, 0);
    check_val("rst_zero", zero_flag, 0);
    check_val("rst_halted", halted, 0);
    m_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  // Acts as both memories; checks every fetch and data request against the model
  task automatic run_prog(input int budget, input int exp_total, input bit expect_halt);
    int since_hs, exp_gap, fw, dw_left, cyc;
    bit in_fetch, in_mem, done;
    logic [PCW-1:0] hold_ia;
    since_hs = 0; exp_gap = 1; fw = 0; dw_left = 0; cyc = 0;
    in_fetch = 1'b0; in_mem = 1'b0; done = 1'b0; hold_ia = '0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++; since_hs++;
      bus.imem_valid = 1'($urandom_range(1, 0)); bus.imem_rdata = 16'($urandom);
      bus.dmem_ready = 1'($urandom_range(1, 0)); bus.dmem_rdata = DW'($urandom);
      if (halted) begin
        check_val("halt_gap", since_hs, exp_gap);
        check_val("halt_model", m_halted, 1);
        if (exp_total > 0) check_val("halt_cycle", cyc - 1, exp_total);
        done = 1'b1;
      end else if (bus.imem_req) begin
        if (!in_fetch) begin
          in_fetch = 1'b1; hold_ia = bus.imem_addr;
          fw = int'($urandom_range(iw_hi, iw_lo));
          check_val("fetch_gap", since_hs, exp_gap);
          check_val("fetch_pc", bus.imem_addr, m_pc);
          check_val("result", result_out, m_result);
          check_val("zero", zero_flag, m_zero);
          check_val("fetch_after_halt", m_halted, 0);
        end else begin
          check_val("iaddr_hold", bus.imem_addr, hold_ia);
        end
        if (fw == 0) begin
          bus.imem_valid = 1'b1; bus.imem_rdata = imem[bus.imem_addr];
          in_fetch = 1'b0; since_hs = 0;
          m_step(imem[bus.imem_addr]);
          exp_gap = m_lat + m_dwait;
        end else begin
          bus.imem_valid = 1'b0; fw--;
        end
      end else if (bus.dmem_req) begin
        if (!in_mem) begin
          in_mem = 1'b1; dw_left = m_dwait;
        end
        check_val("dmem_we", bus.dmem_we, m_dwe);
        check_val("dmem_addr", bus.dmem_addr, m_daddr);
        if (m_dwe == 1) check_val("dmem_wdata", bus.dmem_wdata, m_dwdata);
        if (dw_left == 0) begin
          bus.dmem_ready = 1'b1; in_mem = 1'b0;
          if (bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
          else bus.dmem_rdata = dmem[bus.dmem_addr];
        end else begin
          bus.dmem_ready = 1'b0; dw_left--;
        end
      end
    end
    if (expect_halt) check_val("timeout", done, 1);
  endtask

  initial begin
    int cyc16;
    bus.imem_valid = 1'b0; bus.imem_rdata = 16'h0000;
    bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;

    // LI r1,3; LI r2,5; ADD r3,r1,r2; HALT
    clear_imem();
    imem[0] = 16'h6103; imem[1] = 16'h6205; imem[2] = 16'h1312;
    assert_reset(); release_reset();
    run_prog(200, 15, 1'b1);
    check_val("basic_result", result_out, 8);

    // wrap to zero, then SUB back to 15
    clear_imem();
    imem[0] = 16'h610F; imem[1] = 16'h6201; imem[2] = 16'h1312; imem[3] = 16'h2432;
    assert_reset(); release_reset();
    run_prog(200, 0, 1'b1);
    check_val("ovf_result", result_out, 15);
    check_val("ovf_zero", zero_flag, 0);

    // store/load through address 2 with three data wait cycles
    clear_imem();
    imem[0] = 16'h6109; imem[1] = 16'h8102; imem[2] = 16'h7502;
    dw_lo = 3; dw_hi = 3;
    assert_reset(); release_reset();
    run_prog(200, 0, 1'b1);
    check_val("mem_result", result_out, 9);
    check_val("mem_dmem2", dmem[2], 9);

    // JMP 0x1FF lands on 0xFF
    clear_imem();
    imem[0] = 16'hA1FF; dw_lo = 0; dw_hi = 0;
    assert_reset(); release_reset();
    run_prog(100, 0, 1'b1);

    // BEQ r0,r0,-1 spins on address 0 until reset
    clear_imem();
    imem[0] = 16'h900F; iw_hi = 2;
    assert_reset(); release_reset();
    run_prog(60, 0, 1'b0);
    check_val("beq_loop_addr", bus.imem_addr, 0);
    check_val("beq_loop_halted", halted, 0);

    // dirty registers, then reset in the 2nd wait cycle of the first fetch
    gen_random(30); dw_hi = 3;
    assert_reset(); release_reset();
    run_prog(2000, 0, 1'b1);
    clear_imem();
    for (int k = 1; k < 16; k++) imem[k-1] = {4'h1, 4'h0, 4'(k), 4'h0};
    iw_lo = 5; iw_hi = 5;
    assert_reset(); release_reset();
    @(negedge clk); bus.imem_valid = 1'b0;
    check_val("mf_req_up", bus.imem_req, 1);
    @(negedge clk); bus.imem_valid = 1'b0;
    #1 reset = 1'b1;
    #1 check_val("mf_req_drop", bus.imem_req, 0);
    m_reset();
    release_reset();
    iw_lo = 0; iw_hi = 1;
    run_prog(1000, 0, 1'b1);
    check_val("mf_result", result_out, 0);

    // random programs with random wait states
    for (int p = 0; p < 6; p++) begin
      gen_random(40);
      iw_lo = 0; iw_hi = p % 3; dw_lo = 0; dw_hi = 3;
      assert_reset(); release_reset();
      run_prog(3000, 0, 1'b1);
    end

    // 16-bit data: LI r1,0xAB; ADD r1,r1,r1; opcodes B..E; HALT
    for (int i = 0; i < 256; i++) prog16[i] = 16'hF000;
    prog16[0] = 16'h61AB; prog16[1] = 16'h1111;
    prog16[2] = 16'hB000; prog16[3] = 16'hC123; prog16[4] = 16'hD456; prog16[5] = 16'hE789;
    @(negedge clk); #1 rst16 = 1'b0;
    cyc16 = 0;
    while (!halted16 && cyc16 < 100) begin
      @(negedge clk);
      cyc16++;
    end
    check_val("w16_halted", halted16, 1);
    check_val("w16_cycle", cyc16 - 1, 23);
    check_val("w16_result", result16, 16'h0156);
    check_val("w16_zero", zero16, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the fixed 4-bit processor top. It fetches 16-bit instructions and executes them through a FETCH/DECODE/EXEC/MEM/WB state machine, with data width and PC width set by parameters. Instruction and data memories sit outside the core and are reached through valid/ready-style request handshakes, so wait states are tolerated. `result_out` reports the last value written to a register and replaces the old 4-bit result output.

## Interface
- `DW`, 4: data/register width (4..32).
- `AW`, 4: data-memory address width.
- `PCW`, 8: program-counter / instruction-address width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; all state cleared.
- `imem_req` output 1: instruction fetch request.
- `imem_addr` output PCW: fetch address (= pc).
- `imem_valid` input 1: `imem_rdata` valid; completes the fetch.
- `imem_rdata` input 16: instruction word.
- `dmem_req` output 1: data access request.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output AW: access address.
- `dmem_wdata` output DW: store data.
- `dmem_ready` input 1: access complete; `dmem_rdata` valid the same cycle for loads.
- `dmem_rdata` input DW: load data.
- `result_out` output DW: last value written to the register file.
- `zero_flag` output 1: set when the last ALU result was zero.
- `halted` output 1: core is in HALT.

## Operation
- Instruction format: `op`=[15:12], `rd`=[11:8], `rs`=[7:4], `rt`/`imm4`=[3:0], `imm8`=[7:0], `imm12`=[11:0].
- Registers: 16 x DW; r0 reads as 0 and writes to it are discarded.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd=rs+rt, mod 2^DW.
  - 2 SUB: rd=rs-rt, mod 2^DW.
  - 3 AND, 4 OR, 5 XOR: bitwise into rd.
  - 6 LI: rd=imm8, zero-extended or truncated to DW.
  - 7 LW: rd=mem[(rs+zext imm4)[AW-1:0]].
  - 8 SW: mem[(rs+zext imm4)[AW-1:0]]=rd.
  - 9 BEQ: if rd==rs then pc=pc+1+sext(imm4); otherwise pc=pc+1.
  - A JMP: pc=imm12[PCW-1:0].
  - F HALT.
  - B..E are executed as NOP.
- States:
  - FETCH: `imem_req`=1 and `imem_addr`=pc, both held stable until `imem_valid`. Then latch the instruction and go to DECODE.
  - DECODE: read rs/rt/rd from the register file and go to EXEC.
  - EXEC:
    - ALU ops and LI: compute and go to WB.
    - LW/SW: compute the address and go to MEM.
    - BEQ/JMP/NOP: update pc and go to FETCH.
    - HALT: go to HALT.
  - MEM: `dmem_req`=1, with `dmem_we`, `dmem_addr` and `dmem_wdata` held stable until `dmem_ready`.
    - LW: capture `dmem_rdata` and go to WB.
    - SW: pc=pc+1 and go to FETCH.
  - WB: write rd, update `result_out` (even when rd=r0), pc=pc+1, go to FETCH.
  - HALT: terminal state; only `reset` exits it.
- PC arithmetic wraps mod 2^PCW.
- `zero_flag` updates in EXEC for opcodes 1-5 only.

## Timing
- Reset values: pc=0, state=FETCH, all registers 0, `result_out`=0, `zero_flag`=0, `halted`=0, `imem_req`=0, `dmem_req`=0.
- `imem_req` rises on the first clock edge after reset deasserts.
- Latencies with zero wait states (`imem_valid`/`dmem_ready` high in the first request cycle):
  - ALU op or LI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ, JMP, NOP: 3 cycles.
- Each wait cycle adds exactly one cycle to the instruction.
- Requests are never withdrawn before their handshake completes.
- A valid/ready input seen while no request is pending is ignored.
- `reset` asserted mid-transaction drops `imem_req`/`dmem_req` immediately (asynchronously) and abandons the transaction. No register write occurs.
- `result_out` changes on the WB edge; the new register value is readable by the next instruction's DECODE.
- `halted` rises on the edge that enters HALT.

## Structure
- Shared package `core_pkg`:
  - opcode constants (`OP_NOP`..`OP_HALT`);
  - state enum (`S_FETCH`, `S_DECODE`, `S_EXEC`, `S_MEM`, `S_WB`, `S_HALT`);
  - instruction field position constants.
- Sub-module `core_regfile`:
  - parameter DW;
  - 16 entries, 3 combinational read ports, 1 synchronous write port;
  - r0 forced to 0;
  - async reset clears all entries.
- The ALU stays inline as combinational logic in `multicycle_core`.

## Test plan
- DW=4, no wait states. Program LI r1,3; LI r2,5; ADD r3,r1,r2; HALT -> `result_out` shows 3, then 5, then 8; `halted`=1 at cycle 15.
- Overflow/zero: LI r1,15; LI r2,1; ADD r3,r1,r2 -> `result_out`=0 and `zero_flag`=1. Then SUB r4,r3,r2 -> `result_out`=15 and `zero_flag`=0.
- Memory: SW r1(=9) to address 2, then LW r5 from address 2, with `dmem_ready` delayed 3 cycles -> `dmem_addr`/`dmem_wdata`/`dmem_we` stay stable for all 4 request cycles; `result_out`=9.
- Control flow:
  - BEQ r0,r0 with offset -1 (sext of 4'hF) jumps to itself, so the fetch address stays constant; release it by resetting.
  - JMP 0x1FF with PCW=8 -> `imem_addr`=0xFF.
- Reset mid-fetch: assert `reset` during the 2nd wait cycle of a fetch -> `imem_req`=0 in the same cycle. After release, `imem_addr`=0 and all registers read 0.
- Parameter sweep: DW=16, LI r1,0xAB; ADD r1,r1,r1 -> `result_out`=0x0156. B..E opcodes complete in 3 cycles with no state change.
